fir_window_ctrl: RTL and testbench

Window sequencer for the fixed-point FIR (`FIR_Fixed_top`) datapath. It accepts one N-bit control-bit sample per cycle into an external ring buffer of depth Lookahead+Lookback. It tracks fill level and OSR decimation phase, and issues one compute strobe per OSR accepted samples with the ring addresses of the window's oldest sample and estimate point. A fixed-latency delay line turns that strobe into the output `valid` that the bench waits on.

---
 rtl/fir_window_ctrl.sv | 113 +++++++++++
 tb/tb_fir_window_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fir_window_ctrl.sv
// Window sequencer for the fixed-point FIR datapath: ring-buffer write addressing,
// fill/decimation tracking, and a compute strobe delayed into the result valid.
module fir_window_ctrl #(
   parameter int N         = 3,
   parameter int Lookahead = 220,
   parameter int Lookback  = 220,
   parameter int OSR       = 1,
   parameter int LATENCY   = 4,
   localparam int DEPTH    = Lookahead + Lookback,
   localparam int AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int PW       = (OSR > 2) ? $clog2(OSR) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  in,
   input  logic          in_valid,
   input  logic          clear,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [N-1:0]  wr_data,
   output logic          calc_en,
   output logic [AW-1:0] base_addr,
   output logic [AW-1:0] mid_addr,
   output logic [PW-1:0] osr_phase,
   output logic          filled,
   output logic          valid
);

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [PW-1:0] PLAST   = PW'(OSR - 1);
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LB_W    = (AW+1)'(Lookback);

   state_t          st, st_nxt;
   logic [AW-1:0]   wptr, pend_addr;
   logic [PW-1:0]   wcnt;
   logic            pend, accept, fill_done, win_done;
   logic [LATENCY:1] vld_pipe;

   function automatic logic [AW-1:0] wrap(input logic [AW:0] s);
      return (s >= DEPTH_W) ? AW'(s - DEPTH_W) : AW'(s);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= IDLE;
      else      st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (in_valid) st_nxt = FILL;
         FILL:    if (in_valid && wptr == LAST) st_nxt = RUN;
         RUN:     ;
         default: st_nxt = IDLE;
      endcase
      if (clear) st_nxt = IDLE;
   end

   // During fill the write pointer equals the sample index, so it doubles as the fill count.
   always_comb begin
      accept    = in_valid && !clear;
      fill_done = accept && (st == FILL) && (wptr == LAST);
      win_done  = fill_done || (accept && (st == RUN) && (wcnt == PLAST));
      filled    = (st == RUN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         calc_en   <= 1'b0;
         base_addr <= '0;
         mid_addr  <= '0;
         osr_phase <= '0;
         wptr      <= '0;
         pend_addr <= '0;
         wcnt      <= '0;
         pend      <= 1'b0;
         vld_pipe  <= '0;
      end else begin
         wr_en    <= accept;
         pend     <= win_done;
         calc_en  <= pend && !clear;
         vld_pipe <= (vld_pipe << 1) | LATENCY'(calc_en);
         if (accept) begin
            wr_addr   <= wptr;
            wr_data   <= in;
            pend_addr <= wptr;
            wptr      <= (wptr == LAST) ? '0 : wptr + AW'(1);
            osr_phase <= (osr_phase == PLAST) ? '0 : osr_phase + PW'(1);
            wcnt      <= (win_done || wcnt == PLAST) ? '0 : wcnt + PW'(1);
         end
         // Addresses launch one cycle after the write so the RAM read sees the newest sample.
         if (pend && !clear) begin
            base_addr <= wrap({1'b0, pend_addr} + (AW+1)'(1));
            mid_addr  <= wrap({1'b0, pend_addr} + LB_W);
         end
         if (clear) begin
            wptr      <= '0;
            osr_phase <= '0;
            wcnt      <= '0;
            vld_pipe  <= '0;
         end
      end
   end

   assign valid = vld_pipe[LATENCY];

endmodule

// File: tb/tb_fir_window_ctrl.sv
// Directed bench for fir_window_ctrl: three configurations (OSR=1, OSR=3, DEPTH=5)
// driven with shared stimulus, checked against hand-computed cycle values.
module tb_fir_window_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in;
   logic       in_valid, clear;

   logic       wr_en_a, calc_a, filled_a, valid_a;
   logic [2:0] wr_addr_a, wr_data_a, base_a, mid_a;
   logic [0:0] osr_a;
   logic       wr_en_b, calc_b, filled_b, valid_b;
   logic [2:0] wr_addr_b, wr_data_b, base_b, mid_b;
   logic [1:0] osr_b;
   logic       wr_en_c, calc_c, filled_c, valid_c;
   logic [2:0] wr_addr_c, wr_data_c, base_c, mid_c;
   logic [0:0] osr_c;

   int total = 0;
   int bad   = 0;
   int gap_calc;

   always #5 clk = ~clk;

   fir_window_ctrl #(.N(3), .Lookahead(4), .Lookback(4), .OSR(1), .LATENCY(4)) u_a (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .calc_en(calc_a),
      .base_addr(base_a), .mid_addr(mid_a), .osr_phase(osr_a), .filled(filled_a), .valid(valid_a));

   fir_window_ctrl #(.N(3), .Lookahead(4), .Lookback(4), .OSR(3), .LATENCY(4)) u_b (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .calc_en(calc_b),
      .base_addr(base_b), .mid_addr(mid_b), .osr_phase(osr_b), .filled(filled_b), .valid(valid_b));

   fir_window_ctrl #(.N(3), .Lookahead(3), .Lookback(2), .OSR(1), .LATENCY(4)) u_c (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clear(clear),
      .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .calc_en(calc_c),
      .base_addr(base_c), .mid_addr(mid_c), .osr_phase(osr_c), .filled(filled_c), .valid(valid_c));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench at a negedge with rst released and inputs idle.
   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; clear = 1'b0; in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Loop iteration c: check cycle c (the period after edge c-1), then drive edge c.
   initial begin
      do_reset();
      chk("rst wr_en a", {31'd0, wr_en_a}, 0);
      chk("rst outs a", {wr_addr_a, wr_data_a, base_a, mid_a, osr_a, calc_a, filled_a, valid_a}, 0);
      chk("rst outs b", {wr_addr_b, wr_data_b, base_b, mid_b, osr_b, calc_b, filled_b, valid_b, wr_en_b}, 0);
      chk("rst outs c", {wr_addr_c, wr_data_c, base_c, mid_c, osr_c, calc_c, filled_c, valid_c, wr_en_c}, 0);

      // continuous 16 samples
      for (int c = 0; c < 20; c++) begin
         if (c == 1) begin
            chk("p1 wr_en c1", wr_en_a, 1); chk("p1 wr_addr c1", wr_addr_a, 0); chk("p1 wr_data c1", wr_data_a, 3);
         end
         if (c == 7) chk("p1 filled c7", filled_a, 0);
         if (c == 8) begin
            chk("p1 wr_addr c8", wr_addr_a, 7); chk("p1 filled c8", filled_a, 1); chk("p1 calc c8", calc_a, 0);
         end
         if (c == 9) begin
            chk("p1 wr_addr c9", wr_addr_a, 0); chk("p1 calc c9", calc_a, 1);
            chk("p1 base c9", base_a, 0); chk("p1 mid c9", mid_a, 3);
            chk("b calc c9", calc_b, 1); chk("b base c9", base_b, 0); chk("b mid c9", mid_b, 3);
         end
         if (c == 10) begin
            chk("p1 calc c10", calc_a, 1); chk("p1 base c10", base_a, 1); chk("p1 mid c10", mid_a, 4);
            chk("b calc c10", calc_b, 0); chk("b phase c10", osr_b, 1);
         end
         if (c == 11) begin chk("b calc c11", calc_b, 0); chk("b phase c11", osr_b, 2); end
         if (c == 12) begin
            chk("p1 valid c12", valid_a, 0);
            chk("b calc c12", calc_b, 1); chk("b base c12", base_b, 3); chk("b mid c12", mid_b, 6);
            chk("b phase c12", osr_b, 0);
         end
         if (c == 13) chk("p1 valid c13", valid_a, 1);
         if (c == 15) begin chk("b calc c15", calc_b, 1); chk("b base c15", base_b, 6); chk("b mid c15", mid_b, 1); end
         if (c == 18) begin
            chk("p1 calc c18", calc_a, 0); chk("p1 base hold", base_a, 0); chk("p1 mid hold", mid_a, 3);
         end
         if (c == 5) begin chk("c wr_addr c5", wr_addr_c, 4); chk("c calc c5", calc_c, 0); end
         if (c == 6) begin
            chk("c wr_addr c6", wr_addr_c, 0); chk("c calc c6", calc_c, 1);
            chk("c base c6", base_c, 0); chk("c mid c6", mid_c, 1);
         end
         if (c == 8) begin chk("c calc c8", calc_c, 1); chk("c base c8", base_c, 2); chk("c mid c8", mid_c, 3); end
         in_valid = (c < 16);
         in = 3'(c + 3);
         @(negedge clk);
      end

      // in_valid toggling during fill
      do_reset();
      gap_calc = 0;
      for (int c = 0; c < 21; c++) begin
         if (c >= 1 && c <= 15 && calc_a) gap_calc++;
         if (c == 2) chk("p2 wr_en c2", wr_en_a, 0);
         if (c == 3) begin chk("p2 wr_en c3", wr_en_a, 1); chk("p2 wr_addr c3", wr_addr_a, 1); end
         if (c == 4) chk("p2 b phase c4", osr_b, 2);
         if (c == 5) chk("p2 b phase c5", osr_b, 0);
         if (c == 6) chk("p2 b phase c6", osr_b, 0);
         if (c == 14) chk("p2 filled c14", filled_a, 0);
         if (c == 15) chk("p2 filled c15", filled_a, 1);
         if (c == 16) begin
            chk("p2 gap calc count", gap_calc, 0);
            chk("p2 calc c16", calc_a, 1); chk("p2 base c16", base_a, 0); chk("p2 mid c16", mid_a, 3);
         end
         if (c == 17) chk("p2 calc c17", calc_a, 0);
         if (c == 18) begin chk("p2 calc c18", calc_a, 1); chk("p2 base c18", base_a, 1); chk("p2 mid c18", mid_a, 4); end
         in_valid = (c <= 16) && (c % 2 == 0);
         in = 3'(c);
         @(negedge clk);
      end

      // clear with in_valid in RUN
      do_reset();
      for (int c = 0; c < 22; c++) begin
         if (c == 10) begin
            chk("p3 calc c10", calc_a, 1); chk("p3 wr_en c10", wr_en_a, 1); chk("p3 wr_addr c10", wr_addr_a, 1);
         end
         if (c == 11) begin
            chk("p3 wr_en c11", wr_en_a, 0); chk("p3 calc c11", calc_a, 0);
            chk("p3 filled c11", filled_a, 0); chk("p3 b phase c11", osr_b, 0);
         end
         if (c == 12) begin
            chk("p3 wr_en c12", wr_en_a, 1); chk("p3 wr_addr c12", wr_addr_a, 0);
            chk("p3 wr_data c12", wr_data_a, 3); chk("p3 b phase c12", osr_b, 1);
         end
         if (c == 13) chk("p3 valid c13", valid_a, 0);
         if (c == 14) chk("p3 valid c14", valid_a, 0);
         if (c == 19) chk("p3 calc c19", calc_a, 0);
         if (c == 20) begin chk("p3 calc c20", calc_a, 1); chk("p3 base c20", base_a, 0); chk("p3 mid c20", mid_a, 3); end
         in_valid = (c <= 18);
         clear = (c == 10);
         in = 3'(c);
         @(negedge clk);
      end
      clear = 1'b0;

      // asynchronous reset mid-RUN
      do_reset();
      for (int c = 0; c < 22; c++) begin
         if (c == 11) begin
            chk("p4 calc before rst", calc_a, 1);
            rst = 1'b0;
            #1;
            chk("p4 async outs a", {wr_en_a, wr_addr_a, wr_data_a, calc_a, base_a, mid_a, osr_a, filled_a, valid_a}, 0);
            chk("p4 async outs b", {wr_en_b, wr_addr_b, calc_b, base_b, mid_b, osr_b, filled_b}, 0);
            #1;
            rst = 1'b1;
         end
         if (c == 12) begin
            chk("p4 wr_en c12", wr_en_a, 1); chk("p4 wr_addr c12", wr_addr_a, 0); chk("p4 filled c12", filled_a, 0);
         end
         if (c == 13) chk("p4 valid c13", valid_a, 0);
         if (c == 19) chk("p4 calc c19", calc_a, 0);
         if (c == 20) begin chk("p4 calc c20", calc_a, 1); chk("p4 base c20", base_a, 0); chk("p4 mid c20", mid_a, 3); end
         in_valid = (c <= 19);
         in = 3'(c);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
